// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 shared widths, sext_pack state encoding and field helpers
package lc3_pkg;
    localparam int LC3_W     = 16;
    localparam int IMM5_W    = 5;
    localparam int OFF6_W    = 6;
    localparam int PCOFF9_W  = 9;
    localparam int PCOFF11_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sp_state_t;

    // Widths of 0 or above 16 mean "whole word".
    function automatic logic [4:0] clamp_n(input logic [4:0] n);
        return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
    endfunction

    function automatic logic [15:0] field_mask(input logic [4:0] n);
        if (n >= 5'd16) return 16'hFFFF;
        return (16'd1 << n) - 16'd1;
    endfunction
endpackage

// File: rtl/sext_pack_if.sv
// rtl/sext_pack_if.sv - request/result handshake bundle for sext_pack
interface sext_pack_if;
    import lc3_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [LC3_W-1:0] in_data;
    logic [4:0]       in_n;
    logic             out_valid;
    logic             out_ready;
    logic [LC3_W-1:0] out_field;
    logic             out_fits;
    logic [4:0]       out_minw;

    modport master (
        output in_valid, in_data, in_n, out_ready,
        input  in_ready, out_valid, out_field, out_fits, out_minw
    );
    modport slave (
        input  in_valid, in_data, in_n, out_ready,
        output in_ready, out_valid, out_field, out_fits, out_minw
    );
endinterface

// File: rtl/sext_var.sv
// rtl/sext_var.sv - combinational sign extender from runtime bit n-1
module sext_var
    import lc3_pkg::*;
(
    input  logic [LC3_W-1:0] in_data,
    input  logic [4:0]       n,
    output logic [LC3_W-1:0] out_data
);
    logic [4:0] nn;
    logic [3:0] top;

    always_comb begin
        nn       = clamp_n(n);
        top      = 4'(nn - 5'd1);
        out_data = '0;
        for (int i = 0; i < LC3_W; i++) begin
            out_data[i] = (i < int'(nn)) ? in_data[i] : in_data[top];
        end
    end
endmodule

// File: rtl/sext_pack.sv
// rtl/sext_pack.sv - sign-compression encoder, one redundant sign bit per cycle; SEXT_PACK_CHECK_EN adds a round-trip checker
module sext_pack
    import lc3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    sext_pack_if.slave bus,
    output logic       err
);
    sp_state_t        state, state_next;
    logic [LC3_W-1:0] sh, data_r, field_r;
    logic [4:0]       n_r, minw_r, minw_calc;
    logic [3:0]       cnt;
    logic             out_valid_r, fits_r;
    logic             scan_stop, accept, take;

    assign scan_stop = (sh[15] != sh[14]) || (cnt == 4'd15);
    assign minw_calc = 5'd16 - {1'b0, cnt};
    assign accept    = bus.in_valid && bus.in_ready;
    assign take      = out_valid_r && bus.out_ready;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.out_field = field_r;
    assign bus.out_fits  = fits_r;
    assign bus.out_minw  = minw_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SCAN;
            SCAN:    if (scan_stop) state_next = DONE;
            DONE:    if (take)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // First DONE cycle lets results settle (and the checker look) before out_valid rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh          <= '0;
            data_r      <= '0;
            n_r         <= '0;
            cnt         <= '0;
            field_r     <= '0;
            fits_r      <= 1'b0;
            minw_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sh     <= bus.in_data;
                    data_r <= bus.in_data;
                    n_r    <= clamp_n(bus.in_n);
                    cnt    <= '0;
                end
                SCAN: if (!scan_stop) begin
                    sh  <= {sh[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end else begin
                    field_r <= data_r & field_mask(n_r);
                    fits_r  <= (minw_calc <= n_r);
                    minw_r  <= minw_calc;
                end
                DONE: out_valid_r <= !take;
                default: ;
            endcase
        end
    end

`ifdef SEXT_PACK_CHECK_EN
    logic [LC3_W-1:0] sext_val;
    logic             err_r;

    sext_var u_sext_var (
        .in_data  (field_r),
        .n        (n_r),
        .out_data (sext_val)
    );

    always_ff @(posedge clk) begin
        if (rst)
            err_r <= 1'b0;
        else if (state == DONE && !out_valid_r && fits_r && sext_val != data_r)
            err_r <= 1'b1;
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sext_pack.sv
// tb/tb_sext_pack.sv - self-checking bench for sext_pack: vector table, corner sequences, random vs model
module tb_sext_pack;
    import lc3_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic err;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sext_pack_if bus ();

    sext_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    typedef struct {
        logic [15:0] data;
        logic [4:0]  n;
        logic [15:0] field;
        logic        fits;
        logic [4:0]  minw;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int ref_minw(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        for (int w = 1; w <= 16; w++)
            if (v >= -(1 << (w - 1)) && v < (1 << (w - 1))) return w;
        return 16;
    endfunction

    function automatic int ref_n(input logic [4:0] n);
        return (n == 0 || n > 16) ? 16 : int'(n);
    endfunction

    // Issue one request from a negedge, return outputs and latency in edges after acceptance.
    task automatic do_req(input logic [15:0] d, input logic [4:0] n,
                          output logic [15:0] field, output logic fits,
                          output logic [4:0] minw, output int lat, output logic busy_ok);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_n     = n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_n     = 5'($urandom);
        busy_ok = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
        if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
        field = bus.out_field;
        fits  = bus.out_fits;
        minw  = bus.out_minw;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t        vecs[$];
    logic [15:0] f;
    logic        ft, busy_ok, bad;
    logic [4:0]  mw;
    int          lat;

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_n      = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_field", 32'(bus.out_field), 32'd0);
        check("rst_out_fits", 32'(bus.out_fits), 32'd0);
        check("rst_out_minw", 32'(bus.out_minw), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        vecs.push_back('{16'h000F, 5'(IMM5_W), 16'h000F, 1'b1, 5'd5, 13});
        vecs.push_back('{16'hFFF0, 5'(IMM5_W), 16'h0010, 1'b1, 5'd5, 13});
        vecs.push_back('{16'h0010, 5'(IMM5_W), 16'h0010, 1'b0, 5'd6, 12});
        vecs.push_back('{16'h0000, 5'(PCOFF9_W), 16'h0000, 1'b1, 5'd1, 17});
        vecs.push_back('{16'h8000, 5'(PCOFF11_W), 16'h0000, 1'b0, 5'd16, 2});
        vecs.push_back('{16'h7FFF, 5'd0, 16'h7FFF, 1'b1, 5'd16, 2});
        vecs.push_back('{16'hFFFF, 5'd16, 16'hFFFF, 1'b1, 5'd1, 17});
        vecs.push_back('{16'h0020, 5'(OFF6_W), 16'h0020, 1'b0, 5'd7, 11});
        vecs.push_back('{16'hABCD, 5'd20, 16'hABCD, 1'b1, 5'd16, 2});

        foreach (vecs[i]) begin
            do_req(vecs[i].data, vecs[i].n, f, ft, mw, lat, busy_ok);
            check($sformatf("vec%0d_field", i), 32'(f), 32'(vecs[i].field));
            check($sformatf("vec%0d_fits", i), 32'(ft), 32'(vecs[i].fits));
            check($sformatf("vec%0d_minw", i), 32'(mw), 32'(vecs[i].minw));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
            take_result();
        end

        // Reset in the middle of a scan must drop the request.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        bus.in_n     = 5'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midscan_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midscan_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("midscan_minw_cleared", 32'(bus.out_minw), 32'd0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad = 1'b1;
        end
        check("midscan_no_out_valid", 32'(bad), 32'd0);
        do_req(16'h0003, 5'd5, f, ft, mw, lat, busy_ok);
        check("post_rst_field", 32'(f), 32'h0003);
        check("post_rst_fits", 32'(ft), 32'd1);
        check("post_rst_minw", 32'(mw), 32'd3);
        check("post_rst_latency", 32'(lat), 32'd15);
        take_result();

        // Backpressure: result held stable for 10 cycles.
        do_req(16'hFF00, 5'(PCOFF9_W), f, ft, mw, lat, busy_ok);
        check("bp_field", 32'(f), 32'h0100);
        check("bp_fits", 32'(ft), 32'd1);
        check("bp_minw", 32'(mw), 32'd9);
        check("bp_latency", 32'(lat), 32'd9);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_field !== 16'h0100 || bus.out_fits !== 1'b1 ||
                bus.out_minw !== 5'd9 || bus.in_ready !== 1'b0) bad = 1'b1;
        end
        check("bp_stable", 32'(bad), 32'd0);
        take_result();

        // Random values spread over all magnitudes, widths over the full 5-bit range.
        for (int it = 0; it < 200; it++) begin
            int          w, r, nc, exp_minw, back;
            logic [15:0] d;
            logic [4:0]  n;
            w  = int'($urandom_range(1, 16));
            r  = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            d  = 16'(r);
            n  = 5'($urandom_range(0, 31));
            nc = ref_n(n);
            exp_minw = ref_minw(d);
            bus.out_ready = ($urandom_range(0, 3) == 0);
            do_req(d, n, f, ft, mw, lat, busy_ok);
            check("rnd_field", 32'(f), 32'(int'(d) & ((1 << nc) - 1)));
            check("rnd_minw", 32'(mw), 32'(exp_minw));
            check("rnd_fits", 32'(ft), 32'(exp_minw <= nc));
            check("rnd_latency", 32'(lat), 32'(18 - exp_minw));
            if (ft) begin
                back = int'(f);
                if (back >= (1 << (nc - 1))) back = back - (1 << nc);
                check("rnd_roundtrip", 32'(back), 32'(int'($signed(d))));
            end
            take_result();
            check("rnd_err", 32'(err), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
